dmem_arbiter: RTL and testbench

Shares the single-port data memory between the MEM pipeline stage and a debug/loader port. The pipeline has priority. A starvation counter periodically forces one debug access and stalls the pipeline for that cycle. The block drives the memory's enable, write-enable, address and write data. It routes the 1-cycle-latency read data back to whichever requester issued the read.

---
 rtl/dmem_arbiter.sv | 80 ++++++++
 tb/tb_dmem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM pipeline stage and a debug port.
// The pipeline wins unless a debug request has waited MAX_WAIT cycles, then debug is forced.
module dmem_arbiter #(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_req,
  input  logic                 p_we,
  input  logic [ADDR_SIZE-1:0] p_addr,
  input  logic [WORD_SIZE-1:0] p_wdata,
  output logic                 p_stall,
  output logic [WORD_SIZE-1:0] p_rdata,
  input  logic                 d_valid,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic                 d_rvalid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] r_wcnt;
  logic [3:0] w_wcnt_d;
  logic       r_rsp_p;
  logic       r_rsp_d;
  logic       w_force;
  logic       w_p_gnt;
  logic       w_d_gnt;

  // Grants are masked during reset so the reset output values hold regardless of requests.
  always_comb begin
    w_force = ~rst & d_valid & (r_wcnt == MaxWait);
    w_p_gnt = ~rst & p_req & ~w_force;
    w_d_gnt = ~rst & d_valid & (w_force | ~p_req);
  end

  always_comb begin
    p_stall   = p_req & w_force;
    d_ready   = w_d_gnt;
    mem_en    = w_p_gnt | w_d_gnt;
    mem_we    = w_d_gnt ? d_we : (w_p_gnt & p_we);
    mem_addr  = w_d_gnt ? d_addr : p_addr;
    mem_wdata = w_d_gnt ? d_wdata : p_wdata;
    p_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    d_rvalid  = r_rsp_d;
  end

  always_comb begin
    w_wcnt_d = r_wcnt;
    if (!d_valid || w_d_gnt) begin
      w_wcnt_d = 4'd0;
    end else if (r_wcnt < MaxWait) begin
      w_wcnt_d = r_wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= 4'd0;
      r_rsp_p <= 1'b0;
      r_rsp_d <= 1'b0;
    end else begin
      r_wcnt  <= w_wcnt_d;
      r_rsp_p <= w_p_gnt & ~p_we;
      r_rsp_d <= w_d_gnt & ~d_we;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-first behavioural memory behind the port.
module tb_dmem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, p_we, p_stall;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic          d_valid, d_we, d_ready, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem_q [0:1023];
  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_q[mem_addr];
    end
  end

  task automatic drive_idle();
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    #1;
    n_tests++; if (p_stall !== 1'b0) begin n_fail++; $display("FAIL reset_p_stall got %b want 0", p_stall); end
    n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready got %b want 0", d_ready); end
    n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_d_rvalid got %b want 0", d_rvalid); end
    n_tests++; if ({mem_en, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_mem got %b want 00", {mem_en, mem_we}); end
    n_tests++; if (dut.r_wcnt !== 4'd0) begin n_fail++; $display("FAIL reset_wcnt got %0d want 0", dut.r_wcnt); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    next_cycle();
  endtask

  task automatic test_debug_read_idle();
    d_valid = 1; d_we = 0; d_addr = 10'd5;
    @(negedge clk);
    n_tests++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL dread_ready got %b want 1", d_ready); end
    n_tests++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'd5}) begin n_fail++;
      $display("FAIL dread_mem got en=%b we=%b a=%0d want en=1 we=0 a=5", mem_en, mem_we, mem_addr); end
    next_cycle(); drive_idle();
    @(negedge clk);
    n_tests++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL dread_rvalid got %b want 1", d_rvalid); end
    n_tests++; if (d_rdata !== 32'd5) begin n_fail++; $display("FAIL dread_rdata got %h want 5", d_rdata); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL dread_en_after got %b want 0", mem_en); end
    next_cycle();
  endtask

  task automatic test_force();
    p_req = 1; p_we = 0; p_addr = 10'd1;
    d_valid = 1; d_we = 0; d_addr = 10'd9;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      n_tests++; if (d_ready !== (c == 4)) begin n_fail++; $display("FAIL force_ready c%0d got %b", c, d_ready); end
      n_tests++; if (p_stall !== (c == 4)) begin n_fail++; $display("FAIL force_stall c%0d got %b", c, p_stall); end
      n_tests++; if (dut.r_wcnt !== 4'(c)) begin n_fail++;
        $display("FAIL force_wcnt c%0d got %0d want %0d", c, dut.r_wcnt, c); end
      if (c == 4) begin
        n_tests++; if (mem_addr !== 10'd9) begin n_fail++; $display("FAIL force_addr got %0d want 9", mem_addr); end
      end
      next_cycle();
    end
    d_valid = 0;
    @(negedge clk);
    n_tests++; if (p_stall !== 1'b0) begin n_fail++; $display("FAIL force_c5_stall got %b want 0", p_stall); end
    n_tests++; if (dut.r_wcnt !== 4'd0) begin n_fail++; $display("FAIL force_c5_wcnt got %0d want 0", dut.r_wcnt); end
    n_tests++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL force_c5_rvalid got %b want 1", d_rvalid); end
    n_tests++; if (dut.r_rsp_p !== 1'b0) begin n_fail++; $display("FAIL force_c5_rsp_p got %b want 0", dut.r_rsp_p); end
    n_tests++; if (mem_addr !== 10'd1) begin n_fail++; $display("FAIL force_c5_addr got %0d want 1", mem_addr); end
    next_cycle(); drive_idle(); next_cycle();
  endtask

  task automatic test_pipe_write_wait();
    p_req = 1; p_we = 1; p_addr = 10'd3; p_wdata = 32'hDEADBEEF;
    d_valid = 1; d_we = 0; d_addr = 10'd5;
    @(negedge clk);
    n_tests++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 10'd3}) begin n_fail++;
      $display("FAIL pwr_mem got en=%b we=%b a=%0d want 1 1 3", mem_en, mem_we, mem_addr); end
    n_tests++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pwr_wdata got %h want deadbeef", mem_wdata); end
    n_tests++; if ({p_stall, d_ready} !== 2'b00) begin n_fail++; $display("FAIL pwr_hs got %b want 00", {p_stall, d_ready}); end
    next_cycle(); drive_idle();
    @(negedge clk);
    n_tests++; if (dut.r_wcnt !== 4'd1) begin n_fail++; $display("FAIL pwr_wcnt got %0d want 1", dut.r_wcnt); end
    n_tests++; if ({d_rvalid, dut.r_rsp_p} !== 2'b00) begin n_fail++;
      $display("FAIL pwr_rsp got %b want 00", {d_rvalid, dut.r_rsp_p}); end
    n_tests++; if (mem_q[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pwr_stored got %h want deadbeef", mem_q[3]); end
    next_cycle();
  endtask

  task automatic test_debug_write();
    d_valid = 1; d_we = 1; d_addr = 10'd7; d_wdata = 32'h12345678;
    @(negedge clk);
    n_tests++; if ({d_ready, mem_en, mem_we} !== 3'b111) begin n_fail++;
      $display("FAIL dwr_strobe got %b want 111", {d_ready, mem_en, mem_we}); end
    n_tests++; if (mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL dwr_wdata got %h want 12345678", mem_wdata); end
    next_cycle(); d_we = 0;
    @(negedge clk);
    n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL dwr_no_rvalid got %b want 0", d_rvalid); end
    n_tests++; if ({d_ready, mem_we} !== 2'b10) begin n_fail++; $display("FAIL dwr_rd_grant got %b want 10", {d_ready, mem_we}); end
    next_cycle(); drive_idle();
    @(negedge clk);
    n_tests++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h12345678}) begin n_fail++;
      $display("FAIL dwr_readback got v=%b d=%h want 1 12345678", d_rvalid, d_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    p_req = 1; p_we = 0; p_addr = 10'd2; d_valid = 1; d_we = 0; d_addr = 10'd5;
    next_cycle(); p_req = 0;
    @(negedge clk);
    n_tests++; if ({d_ready, dut.r_wcnt, dut.r_rsp_p} !== {1'b1, 4'd1, 1'b1}) begin n_fail++;
      $display("FAIL rmr_pre got rdy=%b wcnt=%0d rsp_p=%b want 1 1 1", d_ready, dut.r_wcnt, dut.r_rsp_p); end
    rst = 1; p_req = 1; #1;
    n_tests++; if ({dut.r_wcnt, dut.r_rsp_p, dut.r_rsp_d} !== 6'd0) begin n_fail++;
      $display("FAIL rmr_clear got wcnt=%0d rsp_p=%b rsp_d=%b want 0", dut.r_wcnt, dut.r_rsp_p, dut.r_rsp_d); end
    n_tests++; if ({p_stall, d_ready, mem_en, mem_we} !== 4'b0000) begin n_fail++;
      $display("FAIL rmr_outs got %b want 0000", {p_stall, d_ready, mem_en, mem_we}); end
    next_cycle();
    n_tests++; if ({d_rvalid, p_stall, d_ready, mem_en, mem_we} !== 5'b00000) begin n_fail++;
      $display("FAIL rmr_hold got %b want 00000", {d_rvalid, p_stall, d_ready, mem_en, mem_we}); end
    drive_idle();
    @(negedge clk); rst = 0;
    next_cycle();
    n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_after got %b want 0", d_rvalid); end
  endtask

  task automatic test_abandon();
    p_req = 1; p_we = 0; p_addr = 10'd4; d_valid = 1; d_we = 0; d_addr = 10'd6;
    next_cycle(); next_cycle();
    d_valid = 0;
    @(negedge clk);
    n_tests++; if (dut.r_wcnt !== 4'd2) begin n_fail++; $display("FAIL abn_wcnt2 got %0d want 2", dut.r_wcnt); end
    next_cycle();
    n_tests++; if (dut.r_wcnt !== 4'd0) begin n_fail++; $display("FAIL abn_wcnt0 got %0d want 0", dut.r_wcnt); end
    d_valid = 1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      n_tests++; if (d_ready !== (k == 4)) begin n_fail++;
        $display("FAIL abn_ready k%0d got %b want %b", k, d_ready, (k == 4)); end
      next_cycle();
    end
    drive_idle(); next_cycle();
  endtask

  initial begin
    mem_q[5] = 32'd5;
    test_reset();
    test_debug_read_idle();
    test_force();
    test_pipe_write_wait();
    test_debug_write();
    test_reset_mid_read();
    test_abandon();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
